// File: rtl/dsp_mac_nch.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_nch
// Purpose  : Three-stage pipelined signed multiply-accumulate slice with a
//            bank of CHANNELS independent accumulators and valid/ready flow
//            control. Every beat carries its own channel tag and mode.
//              S1: register operands and the pre-adder result
//              S2: register the product
//              S3: accumulator read-modify-write, registered outputs
// Ports    : CLK, RST_N (async active-low), CLR (sync clear of all accs)
//            in_valid/in_ready, in_ch, in_a, in_b, in_d, in_c, in_mode
//              in_mode[0] pre-add enable, [1] pre-subtract (D-B),
//              [2] load (old acc treated as 0), [3] post-subtract
//            out_valid/out_ready, out_ch, out_p, out_ovf
// Macro    : SAT_EN - when defined, overflowing results are clamped to the
//            signed max/min of ACC_WIDTH instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_nch #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int C_WIDTH   = 48,
    parameter int ACC_WIDTH = 48,
    parameter int CHANNELS  = 4,
    parameter int CH_W      = $clog2(CHANNELS)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH_W-1:0]      in_ch,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic [B_WIDTH-1:0]   in_d,
    input  logic [C_WIDTH-1:0]   in_c,
    input  logic [3:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [ACC_WIDTH-1:0] out_p,
    output logic                 out_ovf
);

    localparam int c_PB_W = B_WIDTH + 1;
    localparam int c_M_W  = A_WIDTH + B_WIDTH + 1;
    localparam int c_S_W  = ACC_WIDTH + 2;
    localparam logic [CH_W:0] c_NUM_CH = (CH_W+1)'(CHANNELS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]       s1_ch_q, s1_ch_d;
    logic [A_WIDTH-1:0]    s1_a_q, s1_a_d;
    logic [c_PB_W-1:0]     s1_pb_q, s1_pb_d;
    logic [C_WIDTH-1:0]    s1_c_q, s1_c_d;
    logic                  s1_load_q, s1_load_d;
    logic                  s1_psub_q, s1_psub_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [CH_W-1:0]       s2_ch_q, s2_ch_d;
    logic [c_M_W-1:0]      s2_m_q, s2_m_d;
    logic [C_WIDTH-1:0]    s2_c_q, s2_c_d;
    logic                  s2_load_q, s2_load_d;
    logic                  s2_psub_q, s2_psub_d;

    logic                  s3_valid_q, s3_valid_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic [ACC_WIDTH-1:0]  out_p_q, out_p_d;
    logic                  out_ovf_q, out_ovf_d;

    logic [ACC_WIDTH-1:0]  acc_q [CHANNELS];
    logic [ACC_WIDTH-1:0]  acc_d [CHANNELS];

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic                  w_advance;
    logic [c_PB_W-1:0]     w_b_ext, w_d_ext, w_pb;
    logic signed [c_M_W-1:0] w_a_ext, w_pb_ext, w_m;
    logic                  w_ch_ok;
    logic [ACC_WIDTH-1:0]  w_old;
    logic [c_S_W-1:0]      w_old_ext, w_m_ext, w_c_ext, w_addend, w_sum;
    logic                  w_ovf;
    logic [ACC_WIDTH-1:0]  w_res;

    // The whole pipe moves as one; a full S3 that is not being drained
    // freezes every stage.
    assign w_advance = !s3_valid_q || out_ready;
    assign in_ready  = w_advance;

    assign w_b_ext = {in_b[B_WIDTH-1], in_b};
    assign w_d_ext = {in_d[B_WIDTH-1], in_d};

    always_comb begin
        w_pb = w_b_ext;
        if (in_mode[0]) begin
            w_pb = in_mode[1] ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
        end
    end

    assign w_a_ext  = {{(c_M_W-A_WIDTH){s1_a_q[A_WIDTH-1]}}, s1_a_q};
    assign w_pb_ext = {{(c_M_W-c_PB_W){s1_pb_q[c_PB_W-1]}}, s1_pb_q};
    assign w_m      = w_a_ext * w_pb_ext;

    assign w_ch_ok = ({1'b0, s2_ch_q} < c_NUM_CH);

    // A clear on the same edge as the write means the write starts from 0.
    assign w_old = (s2_load_q || CLR || !w_ch_ok) ? '0 : acc_q[s2_ch_q];

    // Two guard bits are enough: |old| + |m| + |C| < 2^(ACC_WIDTH+1).
    assign w_old_ext = {{2{w_old[ACC_WIDTH-1]}}, w_old};
    assign w_m_ext   = {{(c_S_W-c_M_W){s2_m_q[c_M_W-1]}}, s2_m_q};
    assign w_c_ext   = {{(c_S_W-C_WIDTH){s2_c_q[C_WIDTH-1]}}, s2_c_q};
    assign w_addend  = w_m_ext + w_c_ext;
    assign w_sum     = s2_psub_q ? (w_old_ext - w_addend) : (w_old_ext + w_addend);

    // Fits in ACC_WIDTH signed only if the top three bits agree.
    assign w_ovf = (w_sum[c_S_W-1:ACC_WIDTH-1] != {3{w_sum[c_S_W-1]}});

`ifdef SAT_EN
    always_comb begin
        w_res = w_sum[ACC_WIDTH-1:0];
        if (w_ovf) begin
            w_res = w_sum[c_S_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_res = w_sum[ACC_WIDTH-1:0];
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_a_d     = s1_a_q;
        s1_pb_d    = s1_pb_q;
        s1_c_d     = s1_c_q;
        s1_load_d  = s1_load_q;
        s1_psub_d  = s1_psub_q;
        s2_valid_d = s2_valid_q;
        s2_ch_d    = s2_ch_q;
        s2_m_d     = s2_m_q;
        s2_c_d     = s2_c_q;
        s2_load_d  = s2_load_q;
        s2_psub_d  = s2_psub_q;
        s3_valid_d = s3_valid_q;
        out_ch_d   = out_ch_q;
        out_p_d    = out_p_q;
        out_ovf_d  = out_ovf_q;

        if (w_advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ch_d   = in_ch;
                s1_a_d    = in_a;
                s1_pb_d   = w_pb;
                s1_c_d    = in_c;
                s1_load_d = in_mode[2];
                s1_psub_d = in_mode[3];
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_ch_d   = s1_ch_q;
                s2_m_d    = w_m;
                s2_c_d    = s1_c_q;
                s2_load_d = s1_load_q;
                s2_psub_d = s1_psub_q;
            end

            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_ch_d  = s2_ch_q;
                out_p_d   = w_ch_ok ? w_res : '0;
                out_ovf_d = w_ch_ok && w_ovf;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            acc_d[i] = CLR ? '0 : acc_q[i];
        end
        if (w_advance && s2_valid_q && w_ch_ok) begin
            acc_d[s2_ch_q] = w_res;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_a_q     <= '0;
            s1_pb_q    <= '0;
            s1_c_q     <= '0;
            s1_load_q  <= 1'b0;
            s1_psub_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            s2_m_q     <= '0;
            s2_c_q     <= '0;
            s2_load_q  <= 1'b0;
            s2_psub_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            out_ch_q   <= '0;
            out_p_q    <= '0;
            out_ovf_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_a_q     <= s1_a_d;
            s1_pb_q    <= s1_pb_d;
            s1_c_q     <= s1_c_d;
            s1_load_q  <= s1_load_d;
            s1_psub_q  <= s1_psub_d;
            s2_valid_q <= s2_valid_d;
            s2_ch_q    <= s2_ch_d;
            s2_m_q     <= s2_m_d;
            s2_c_q     <= s2_c_d;
            s2_load_q  <= s2_load_d;
            s2_psub_q  <= s2_psub_d;
            s3_valid_q <= s3_valid_d;
            out_ch_q   <= out_ch_d;
            out_p_q    <= out_p_d;
            out_ovf_q  <= out_ovf_d;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign out_valid = s3_valid_q;
    assign out_ch    = out_ch_q;
    assign out_p     = out_p_q;
    assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_nch
// Purpose  : Directed self-checking bench for dsp_mac_nch (default params).
//            Build with SAT_EN defined to check the saturating variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_nch;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CLR;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic [17:0] in_d;
    logic [47:0] in_c;
    logic [3:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [47:0] out_p;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Completed output handshakes, captured half a cycle before the edge
    logic [1:0]  mon_ch  [$];
    logic [47:0] mon_p   [$];
    logic        mon_ovf [$];
    int          mon_cyc [$];

    dsp_mac_nch dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLR       (CLR),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_d      (in_d),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_p     (out_p),
        .out_ovf   (out_ovf)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always begin
        @(negedge CLK);
        #1;
        if (RST_N && out_valid && out_ready) begin
            mon_ch.push_back(out_ch);
            mon_p.push_back(out_p);
            mon_ovf.push_back(out_ovf);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic flush_mon();
        mon_ch.delete();
        mon_p.delete();
        mon_ovf.delete();
        mon_cyc.delete();
    endtask

    // Present one beat and hold it until accepted; returns after the
    // accepting edge (at the following falling edge) with in_valid low.
    task automatic send(input logic [1:0] ch, input logic [17:0] a,
                        input logic [17:0] b, input logic [17:0] d,
                        input logic [47:0] c, input logic [3:0] mode);
        int guard = 0;
        in_ch = ch; in_a = a; in_b = b; in_d = d; in_c = c; in_mode = mode;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 50 cycles");
        end
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int guard = 0;
        while (mon_p.size() < n && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        #2;
        if (mon_p.size() < n) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got %0d results want %0d", mon_p.size(), n);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CLR = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ch = '0; in_a = '0; in_b = '0; in_d = '0; in_c = '0; in_mode = '0;
        repeat (2) @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
        checks++; if (out_p !== 48'd0) begin errors++; $display("FAIL rst_out_p: got %0h want 0", out_p); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf: got %b want 0", out_ovf); end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b want 0", out_valid); end
    endtask

    // 3*4 = 12 on ch0; out_valid must rise after exactly the third edge.
    task automatic test_latency();
        in_ch = 2'd0; in_a = 18'd3; in_b = 18'd4; in_d = 18'd0; in_c = 48'd0; in_mode = 4'd0;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1: got out_valid=%b want 0", out_valid); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge2: got out_valid=%b want 0", out_valid); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_edge3: got out_valid=%b want 1", out_valid); end
        checks++; if (out_p !== 48'd12) begin errors++; $display("FAIL lat_p: got %0d want 12", out_p); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL lat_ch: got %0d want 0", out_ch); end
        @(negedge CLK);
        #2;
        flush_mon();
    endtask

    // ch1: 4 x (2*5+1) accumulates 11..44 at full rate; ch0 goes 12 -> 13.
    task automatic test_back_to_back();
        logic [47:0] exp_p [5];
        logic [1:0]  exp_ch [5];
        exp_p  = '{48'd11, 48'd22, 48'd33, 48'd44, 48'd13};
        exp_ch = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) send(2'd1, 18'd2, 18'd5, 18'd0, 48'd1, 4'd0);
        send(2'd0, 18'd1, 18'd1, 18'd0, 48'd0, 4'd0);
        wait_results(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mon_p[i] !== exp_p[i] || mon_ch[i] !== exp_ch[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: got ch%0d p=%0d want ch%0d p=%0d", i, mon_ch[i], mon_p[i], exp_ch[i], exp_p[i]);
            end
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (mon_cyc[i] - mon_cyc[i-1] !== 1) begin
                errors++;
                $display("FAIL b2b_rate[%0d]: got gap %0d want 1", i, mon_cyc[i] - mon_cyc[i-1]);
            end
        end
        flush_mon();
    endtask

    // Pre-subtract with load, post-subtract, pre-add, negative C.
    task automatic test_modes();
        logic [47:0] exp_p [4];
        exp_p = '{-48'sd9, -48'sd14, -48'sd5, -48'sd7};
        send(2'd1, -18'sd2, 18'd3, 18'd10, 48'd5, 4'b0111); // load: 0 + (-2*(10-3)) + 5
        send(2'd3, 18'd3, 18'd4, 18'd0, 48'd2, 4'b1000);    // 0 - (12 + 2)
        send(2'd3, 18'd3, 18'd2, 18'd1, 48'd0, 4'b0001);    // -14 + 3*(1+2)
        send(2'd0, 18'd0, 18'd0, 18'd0, -48'sd20, 4'b0000); // 13 - 20
        wait_results(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_p[i] !== exp_p[i] || mon_ovf[i] !== 1'b0) begin
                errors++;
                $display("FAIL modes[%0d]: got p=%0h ovf=%b want p=%0h ovf=0", i, mon_p[i], mon_ovf[i], exp_p[i]);
            end
        end
        flush_mon();
    endtask

    // out_ready low for 5 cycles while six +1 beats stream into ch3 (-5).
    task automatic test_stall();
        fork
            begin
                for (int i = 0; i < 6; i++) send(2'd3, 18'd1, 18'd1, 18'd0, 48'd0, 4'd0);
            end
            begin
                out_ready = 1'b0;
                for (int i = 1; i <= 5; i++) begin
                    @(negedge CLK);
                    if (i >= 3) begin
                        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
                        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
                        checks++; if (out_p !== -48'sd4 || out_ch !== 2'd3) begin errors++; $display("FAIL stall_hold[%0d]: got ch%0d p=%0h want ch3 p=%0h", i, out_ch, out_p, -48'sd4); end
                    end
                    if (i == 5) out_ready = 1'b1;
                end
            end
        join
        wait_results(6);
        repeat (4) @(negedge CLK);
        checks++;
        if (mon_p.size() !== 6) begin errors++; $display("FAIL stall_count: got %0d want 6", mon_p.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mon_p[i] !== 48'(i - 4) || mon_ch[i] !== 2'd3) begin
                errors++;
                $display("FAIL stall_seq[%0d]: got ch%0d p=%0h want ch3 p=%0h", i, mon_ch[i], mon_p[i], 48'(i - 4));
            end
        end
        flush_mon();
    endtask

    task automatic test_overflow();
        logic [47:0] exp_p [4];
        logic        exp_o [4];
`ifdef SAT_EN
        exp_p = '{48'h7FFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 48'h8000_0000_0000};
`else
        exp_p = '{48'h7FFF_FFFF_FFFF, 48'h8000_0000_0009, 48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF};
`endif
        exp_o = '{1'b0, 1'b1, 1'b0, 1'b1};
        send(2'd2, 18'd0, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 4'b0100); // load max
        send(2'd2, 18'd2, 18'd5, 18'd0, 48'd0, 4'b0000);              // + 10
        send(2'd0, 18'd0, 18'd0, 18'd0, 48'h8000_0000_0000, 4'b0100); // load min
        send(2'd0, 18'd1, 18'd1, 18'd0, 48'd0, 4'b1000);              // - 1
        wait_results(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_p[i] !== exp_p[i] || mon_ovf[i] !== exp_o[i]) begin
                errors++;
                $display("FAIL ovf[%0d]: got p=%0h ovf=%b want p=%0h ovf=%b", i, mon_p[i], mon_ovf[i], exp_p[i], exp_o[i]);
            end
        end
        flush_mon();
    endtask

    // CLR coincides with the S2->S3 write of 7*1 to ch2.
    task automatic test_clear();
        logic [47:0] exp_p [4];
        exp_p = '{48'd0, 48'd0, 48'd7, 48'd0};
        @(negedge CLK);
        in_ch = 2'd2; in_a = 18'd7; in_b = 18'd1; in_d = 18'd0; in_c = 48'd0; in_mode = 4'd0;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_p !== 48'd7 || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL clr_write: got v=%b ch%0d p=%0h want v=1 ch2 p=7", out_valid, out_ch, out_p);
        end
        @(negedge CLK);
        #2;
        flush_mon();
        for (int i = 0; i < 4; i++) send(2'(i), 18'd0, 18'd0, 18'd0, 48'd0, 4'd0);
        wait_results(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL clr_acc[%0d]: got %0h want %0h", i, mon_p[i], exp_p[i]);
            end
        end
        flush_mon();
    endtask

    task automatic test_reset_midstream();
        send(2'd1, 18'd1, 18'd1, 18'd0, 48'd0, 4'd0);
        send(2'd1, 18'd1, 18'd1, 18'd0, 48'd0, 4'd0);
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        #2;
        checks++; if (mon_p.size() !== 0) begin errors++; $display("FAIL mid_rst_leak: got %0d results want 0", mon_p.size()); end
        flush_mon();
        send(2'd1, 18'd0, 18'd0, 18'd0, 48'd0, 4'd0);
        wait_results(1);
        checks++; if (mon_p[0] !== 48'd0) begin errors++; $display("FAIL mid_rst_acc: got %0h want 0", mon_p[0]); end
        flush_mon();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_modes();
        test_stall();
        test_overflow();
        test_clear();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
